// File: rtl/sweepctl_pkg.sv
// Shared definitions for the triangle-sweep sequencer and its bench.
// State encodings are fixed so waveforms and the bench agree on them.
package sweepctl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    UP   = 2'd2,
    DOWN = 2'd3
  } state_t;

endpackage

// File: rtl/sweepctl_cnt.sv
// N-bit load/up/down counter driven by sweepctl.
// The load input has priority over counting.
module sweepctl_cnt #(
  parameter int N = 4
) (
  input  logic         ck,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] val,
  input  logic         up,
  output logic [N-1:0] cnt
);

  logic [N-1:0] r_cnt;

  always_ff @(posedge ck) begin
    if (rst)
      r_cnt <= '0;
    else if (load)
      r_cnt <= val;
    else if (up)
      r_cnt <= r_cnt + {{(N-1){1'b0}}, 1'b1};
    else
      r_cnt <= r_cnt - {{(N-1){1'b0}}, 1'b1};
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/sweepgen.sv
// System wrapper pairing the sweep sequencer with its counter at a common width.
module sweepgen #(
  parameter int N = 4
) (
  input  logic         ck,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic [N-1:0] lo,
  input  logic [N-1:0] hi,
  output logic [N-1:0] cnt,
  output logic         busy,
  output logic         wrap,
  output logic         err
);

  logic         w_load;
  logic [N-1:0] w_val;
  logic         w_up;

  sweepctl #(.N(N)) u_ctl (
    .ck    (ck),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .lo    (lo),
    .hi    (hi),
    .cnt   (cnt),
    .load  (w_load),
    .val   (w_val),
    .up    (w_up),
    .busy  (busy),
    .wrap  (wrap),
    .err   (err)
  );

  sweepctl_cnt #(.N(N)) u_cnt (
    .ck   (ck),
    .rst  (rst),
    .load (w_load),
    .val  (w_val),
    .up   (w_up),
    .cnt  (cnt)
  );

endmodule

// File: rtl/sweepctl.sv
// Sequencer that steers an external load/up/down counter through a
// bounded triangle sweep lo..hi..lo, with start/stop control and status pulses.
module sweepctl
  import sweepctl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         ck,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic [N-1:0] lo,
  input  logic [N-1:0] hi,
  input  logic [N-1:0] cnt,
  output logic         load,
  output logic [N-1:0] val,
  output logic         up,
  output logic         busy,
  output logic         wrap,
  output logic         err
);

  state_t       r_state;
  state_t       w_next;
  logic [N-1:0] r_lo_q;
  logic [N-1:0] r_hi_q;
  logic         r_wrap;
  logic         r_err;
  logic         w_capture;
  logic         w_wrap_nxt;
  logic         w_err_nxt;
  logic [N-1:0] w_hi_m1;
  logic [N-1:0] w_lo_p1;

  // Turn-around points sit one step inside the bounds so the counter lands exactly on them.
  assign w_hi_m1 = r_hi_q - {{(N-1){1'b0}}, 1'b1};
  assign w_lo_p1 = r_lo_q + {{(N-1){1'b0}}, 1'b1};

  always_ff @(posedge ck) begin
    if (rst) begin
      r_state <= IDLE;
      r_lo_q  <= '0;
      r_hi_q  <= '0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wrap  <= w_wrap_nxt;
      r_err   <= w_err_nxt;
      if (w_capture) begin
        r_lo_q <= lo;
        r_hi_q <= hi;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_capture  = 1'b0;
    w_wrap_nxt = 1'b0;
    w_err_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !stop) begin
          if (lo < hi) begin
            w_capture = 1'b1;
            w_next    = LOAD;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      LOAD: w_next = UP;
      UP: begin
        if (cnt == w_hi_m1)
          w_next = DOWN;
      end
      DOWN: begin
        if (cnt == w_lo_p1) begin
          w_next     = UP;
          w_wrap_nxt = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
    // A stop freezes the counter where it is, so no bound is reached and no wrap is due.
    if (stop) begin
      w_next     = IDLE;
      w_wrap_nxt = 1'b0;
    end
  end

  always_comb begin
    load = 1'b1;
    val  = cnt;
    up   = 1'b1;
    case (r_state)
      LOAD: val = r_lo_q;
      UP: begin
        load = 1'b0;
        up   = 1'b1;
      end
      DOWN: begin
        load = 1'b0;
        up   = 1'b0;
      end
      default: ;
    endcase
    if (stop) begin
      load = 1'b1;
      val  = cnt;
      up   = 1'b1;
    end
  end

  assign busy = (r_state != IDLE);
  assign wrap = r_wrap;
  assign err  = r_err;

endmodule
